// File: rtl/mlp_fprop_tile.sv
// Two-layer fixed-point MLP forward pass: streams one weight column per beat,
// activates each layer in a single cycle, then does a sequential argmax.
module mlp_fprop_tile #(
  parameter int IN_SZ    = 784,
  parameter int HID_SZ   = 128,
  parameter int OUT_SZ   = 10,
  parameter int DW       = 32,
  parameter int FRAC     = 16,
  parameter int ACT_MODE = 1,
  localparam int MAX_SZ  = (IN_SZ > HID_SZ) ? IN_SZ : HID_SZ,
  localparam int IDX_W   = $clog2(MAX_SZ) + 1,
  localparam int CI_W    = $clog2(OUT_SZ),
  localparam int AM_W    = $clog2(OUT_SZ) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [IN_SZ*DW-1:0]  i_image,
  input  logic                 i_w_valid,
  output logic                 o_w_ready,
  input  logic [HID_SZ*DW-1:0] i_w_data,
  output logic                 o_w_layer,
  output logic [IDX_W-1:0]     o_w_idx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [OUT_SZ*DW-1:0] o_result,
  output logic [CI_W-1:0]      o_class_idx
);

  typedef enum logic [2:0] {S_IDLE, S_L0, S_ACT0, S_L1, S_ACT1, S_ARGMAX, S_DONE} state_t;

  localparam logic signed [DW-1:0]   P_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   P_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [2*DW-1:0] W_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] W_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]   ONE   = {{(DW-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [DW-1:0]   HALF  = {{(DW-1){1'b0}}, 1'b1} << (FRAC-1);

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [AM_W-1:0]       r_am;
  logic                  r_done;
  logic [CI_W-1:0]       r_class;
  logic signed [DW-1:0]  r_best_val;
  logic [CI_W-1:0]       r_best_idx;
  logic signed [DW-1:0]  r_image  [IN_SZ];
  logic signed [DW-1:0]  r_acc0   [HID_SZ];
  logic signed [DW-1:0]  r_hidden [HID_SZ];
  logic signed [DW-1:0]  r_acc1   [OUT_SZ];
  logic signed [DW-1:0]  r_result [OUT_SZ];

  logic signed [DW-1:0]  w_pix;
  logic signed [DW-1:0]  w_hid;
  logic signed [DW-1:0]  w_cand;
  logic signed [DW-1:0]  w_best_val;
  logic [CI_W-1:0]       w_best_idx;

  // Product is floored by the arithmetic shift, then clamped to DW.
  function automatic logic signed [DW-1:0] f_mul(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    logic signed [2*DW-1:0] s;
    p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    s = p >>> FRAC;
    if (s > W_MAX)      return P_MAX;
    else if (s < W_MIN) return P_MIN;
    else                return s[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] f_add(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) return s[DW] ? P_MIN : P_MAX;
    else                  return s[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] f_act(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] t;
    if (ACT_MODE == 0) return x[DW-1] ? '0 : x;
    t = (x >>> 2) + HALF;
    if (t[DW-1])       return '0;
    else if (t > ONE)  return ONE;
    else               return t;
  endfunction

  always_comb begin
    w_pix = '0;
    for (int k = 0; k < IN_SZ; k++)
      if (r_idx == IDX_W'(k)) w_pix = r_image[k];
    w_hid = '0;
    for (int j = 0; j < HID_SZ; j++)
      if (r_idx == IDX_W'(j)) w_hid = r_hidden[j];
    w_cand = '0;
    for (int m = 0; m < OUT_SZ; m++)
      if (r_am == AM_W'(m)) w_cand = r_result[m];
    // First compare seeds the running max; later ones replace only on strictly greater.
    w_best_val = r_best_val;
    w_best_idx = r_best_idx;
    if (r_am == '0 || w_cand > r_best_val) begin
      w_best_val = w_cand;
      w_best_idx = r_am[CI_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_am       <= '0;
      r_done     <= 1'b0;
      r_class    <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
      for (int k = 0; k < IN_SZ; k++)  r_image[k]  <= '0;
      for (int n = 0; n < HID_SZ; n++) begin
        r_acc0[n]   <= '0;
        r_hidden[n] <= '0;
      end
      for (int m = 0; m < OUT_SZ; m++) begin
        r_acc1[m]   <= '0;
        r_result[m] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (i_abort && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (i_start) begin
            for (int k = 0; k < IN_SZ; k++) r_image[k] <= i_image[k*DW +: DW];
            for (int n = 0; n < HID_SZ; n++) r_acc0[n] <= '0;
            for (int m = 0; m < OUT_SZ; m++) r_acc1[m] <= '0;
            r_idx   <= '0;
            r_state <= S_L0;
          end
          S_L0: if (i_w_valid) begin
            for (int n = 0; n < HID_SZ; n++)
              r_acc0[n] <= f_add(r_acc0[n], f_mul(w_pix, i_w_data[n*DW +: DW]));
            if (r_idx == IDX_W'(IN_SZ-1)) begin
              r_idx   <= '0;
              r_state <= S_ACT0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          S_ACT0: begin
            for (int n = 0; n < HID_SZ; n++) r_hidden[n] <= f_act(r_acc0[n]);
            r_idx   <= '0;
            r_state <= S_L1;
          end
          S_L1: if (i_w_valid) begin
            for (int m = 0; m < OUT_SZ; m++)
              r_acc1[m] <= f_add(r_acc1[m], f_mul(w_hid, i_w_data[m*DW +: DW]));
            if (r_idx == IDX_W'(HID_SZ-1)) begin
              r_idx   <= '0;
              r_state <= S_ACT1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          S_ACT1: begin
            for (int m = 0; m < OUT_SZ; m++) r_result[m] <= f_act(r_acc1[m]);
            r_am    <= '0;
            r_state <= S_ARGMAX;
          end
          S_ARGMAX: begin
            r_best_val <= w_best_val;
            r_best_idx <= w_best_idx;
            if (r_am == AM_W'(OUT_SZ-1)) begin
              r_class <= w_best_idx;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_am <= r_am + 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_w_ready   = (r_state == S_L0) || (r_state == S_L1);
  assign o_w_layer   = (r_state == S_L1);
  assign o_w_idx     = r_idx;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_class_idx = r_class;

  always_comb begin
    o_result = '0;
    for (int m = 0; m < OUT_SZ; m++) o_result[m*DW +: DW] = r_result[m];
  end

endmodule

// File: tb/tb_mlp_fprop_tile.sv
// Bench for mlp_fprop_tile (4-3-3, Q16.16, ReLU): arithmetic reference model,
// per-cycle output checker, directed inference scenarios.
module tb_mlp_fprop_tile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [127:0] i_image = '0;
  logic        i_w_valid = 1'b0;
  logic        o_w_ready;
  logic [95:0] i_w_data = '0;
  logic        o_w_layer;
  logic [2:0]  o_w_idx;
  logic        o_busy;
  logic        o_done;
  logic [95:0] o_result;
  logic [1:0]  o_class_idx;

  mlp_fprop_tile #(.IN_SZ(4), .HID_SZ(3), .OUT_SZ(3), .DW(32), .FRAC(16), .ACT_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_image(i_image),
    .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data), .o_w_layer(o_w_layer),
    .o_w_idx(o_w_idx), .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_class_idx(o_class_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam longint LMAX = 64'sh7FFFFFFF;
  localparam longint LMIN = -64'sh80000000;

  logic [31:0] img [4];
  logic [31:0] W0 [4][3];
  logic [31:0] W1 [3][3];
  logic [31:0] m_res [3];
  int          m_cls;
  logic [31:0] exp_res [3];
  int          exp_cls = 0;
  int          c_beg = 1, c_end = 0, done_at = -1;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_sat(input longint v);
    if (v > LMAX) return 32'h7FFFFFFF;
    if (v < LMIN) return 32'h80000000;
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return m_sat(p >>> 16);
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    return m_sat(longint'($signed(a)) + longint'($signed(b)));
  endfunction

  function automatic logic [31:0] m_relu(input logic [31:0] x);
    return ($signed(x) < 0) ? 32'h0 : x;
  endfunction

  function automatic void m_model();
    logic [31:0] a0 [3];
    logic [31:0] h [3];
    logic [31:0] a1 [3];
    for (int n = 0; n < 3; n++) begin
      a0[n] = 32'h0;
      for (int k = 0; k < 4; k++) a0[n] = m_add(a0[n], m_mul(img[k], W0[k][n]));
      h[n] = m_relu(a0[n]);
    end
    for (int m = 0; m < 3; m++) begin
      a1[m] = 32'h0;
      for (int j = 0; j < 3; j++) a1[m] = m_add(a1[m], m_mul(h[j], W1[j][m]));
      m_res[m] = m_relu(a1[m]);
    end
    m_cls = 0;
    for (int m = 1; m < 3; m++)
      if ($signed(m_res[m]) > $signed(m_res[m_cls])) m_cls = m;
  endfunction

  function automatic void set_all(input logic [31:0] v);
    for (int k = 0; k < 4; k++) begin
      img[k] = v;
      for (int n = 0; n < 3; n++) W0[k][n] = v;
    end
    for (int j = 0; j < 3; j++)
      for (int m = 0; m < 3; m++) W1[j][m] = v;
  endfunction

  // Output checker: busy/done timing every cycle; result/class whenever they must be stable.
  always @(negedge clk) begin
    bit eb;
    eb = (cyc >= c_beg) && (cyc <= c_end);
    chk("busy", o_busy, eb);
    chk("done", o_done, cyc == done_at);
    if (!eb || cyc == done_at) begin
      for (int m = 0; m < 3; m++) chk("result", o_result[m*32 +: 32], exp_res[m]);
      chk("class_idx", o_class_idx, exp_cls);
    end
  end

  // mode 0: normal, 1: abort on L1 beat 1, 2: reset pulse during ARGMAX
  task automatic run_inf(input int gap_at, input int gap_len, input int mode);
    m_model();
    for (int k = 0; k < 4; k++) i_image[k*32 +: 32] = img[k];
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    c_beg = cyc;
    if (mode == 1) begin
      c_end   = cyc + 1000;
      done_at = -1;
    end else begin
      c_end   = cyc + 12 + gap_len;
      done_at = c_end;
      exp_res = m_res;
      exp_cls = m_cls;
    end
    for (int k = 0; k < 4; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          i_w_valid = 1'b0;
          i_w_data  = {3{32'h00070000}};
          chk("gap_idx", o_w_idx, k);
          @(posedge clk); #1;
        end
      end
      i_w_valid = 1'b1;
      for (int n = 0; n < 3; n++) i_w_data[n*32 +: 32] = W0[k][n];
      chk("l0_ready", o_w_ready, 1);
      chk("l0_layer", o_w_layer, 0);
      chk("l0_idx", o_w_idx, k);
      @(posedge clk); #1;
    end
    i_w_data = {3{32'h00050000}};
    chk("act0_ready", o_w_ready, 0);
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      for (int m = 0; m < 3; m++) i_w_data[m*32 +: 32] = W1[j][m];
      chk("l1_ready", o_w_ready, 1);
      chk("l1_layer", o_w_layer, 1);
      chk("l1_idx", o_w_idx, j);
      if (mode == 1 && j == 1) begin
        i_abort = 1'b1;
        c_end   = cyc;
        @(posedge clk); #1;
        i_abort   = 1'b0;
        i_w_valid = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_ready", o_w_ready, 0);
        repeat (16) @(posedge clk);
        #1;
        return;
      end
      @(posedge clk); #1;
    end
    i_w_valid = 1'b0;
    if (mode == 2) begin
      @(posedge clk); #1;
      c_end   = cyc - 1;
      done_at = -1;
      exp_res = '{default: 32'h0};
      exp_cls = 0;
      rst_n   = 1'b0;
      #1;
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_ready", o_w_ready, 0);
      chk("rst_layer", o_w_layer, 0);
      chk("rst_idx", o_w_idx, 0);
      chk("rst_result", o_result, 0);
      chk("rst_class", o_class_idx, 0);
      i_start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_ignored", o_busy, 0);
      i_start = 1'b0;
      rst_n   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      return;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_res = '{default: 32'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", o_w_ready, 0);
    chk("reset_layer", o_w_layer, 0);
    chk("reset_idx", o_w_idx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("pin_mul_floor", m_mul(32'hFFFFFFFF, 32'h00008000), 32'hFFFFFFFF);
    chk("pin_mul_sat", m_mul(32'h7FFF0000, 32'h7FFF0000), 32'h7FFFFFFF);

    // All ones: hidden 4.0, result 12.0, tie -> class 0
    set_all(32'h00010000);
    m_model();
    chk("pin_t1_res", m_res[1], 32'h000C0000);
    chk("pin_t1_cls", m_cls, 0);
    run_inf(-1, 0, 0);
    for (int m = 0; m < 3; m++) chk("t1_result_lit", o_result[m*32 +: 32], 32'h000C0000);
    chk("t1_class_lit", o_class_idx, 0);

    // Same with a 5-cycle stall in the middle of layer 0
    run_inf(2, 5, 0);
    chk("t2_result_lit", o_result[63:32], 32'h000C0000);

    // Layer-1 columns (0.5, -1.0, 2.0)
    set_all(32'h00010000);
    for (int j = 0; j < 3; j++) begin
      W1[j][0] = 32'h00008000;
      W1[j][1] = 32'hFFFF0000;
      W1[j][2] = 32'h00020000;
    end
    m_model();
    chk("pin_t3_res0", m_res[0], 32'h00060000);
    chk("pin_t3_res1", m_res[1], 32'h0);
    chk("pin_t3_res2", m_res[2], 32'h00180000);
    run_inf(-1, 0, 0);
    chk("t3_result_lit", o_result, {32'h00180000, 32'h0, 32'h00060000});
    chk("t3_class_lit", o_class_idx, 2);

    // Saturation everywhere
    set_all(32'h7FFF0000);
    run_inf(-1, 0, 0);
    chk("t4_result_lit", o_result, {3{32'h7FFFFFFF}});

    // Mixed signs and fractions
    img[0] = 32'h00018000; img[1] = 32'hFFFE0000; img[2] = 32'h00004000; img[3] = 32'h00030000;
    for (int k = 0; k < 4; k++)
      for (int n = 0; n < 3; n++)
        W0[k][n] = ((k + n) % 2 == 1) ? -32'(16384 * (k + n + 1)) : 32'(16384 * (k + n + 1));
    for (int j = 0; j < 3; j++)
      for (int m = 0; m < 3; m++) W1[j][m] = (m == 1) ? 32'h00010000 : 32'h00002000;
    run_inf(-1, 0, 0);

    // Abort in layer 1, then a clean inference
    set_all(32'h00010000);
    run_inf(-1, 0, 1);
    run_inf(-1, 0, 0);

    // Reset during ARGMAX, then the first start after reset
    set_all(32'h00010000);
    for (int j = 0; j < 3; j++) begin
      W1[j][0] = 32'h00008000;
      W1[j][1] = 32'hFFFF0000;
      W1[j][2] = 32'h00020000;
    end
    run_inf(-1, 0, 2);
    run_inf(-1, 0, 0);
    chk("t9_class_lit", o_class_idx, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
